// File: rtl/keystroke_print_ctrl.sv
// Line-buffered keyboard echo: collects UART bytes into a character buffer, then
// walks the message ROM and feeds each byte to the UART transmitter.
module keystroke_print_ctrl #(
  parameter int MSG_CHARS = 8,
  parameter int LAST_ADDR = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [8*MSG_CHARS-1:0] bits_out,
  output logic [3:0]             rom_addr,
  input  logic [7:0]             rom_data,
  output logic [7:0]             tx_data,
  output logic                   tx_new_data,
  input  logic                   tx_busy,
  output logic                   printing,
  output logic                   rx_drop,
  output logic [1:0]             state_dbg
);

  // Handshakes: rx_valid is a one-cycle strobe qualifying rx_data; tx_new_data is
  // a one-cycle strobe issued only when tx_busy was low at the sampling edge, and
  // tx_busy is expected to rise on the edge after the strobe.
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] wr_idx;
  logic       is_enter;
  logic       line_full;
  logic       trigger;

  assign is_enter  = (rx_data == 8'h0D);
  assign line_full = (wr_idx == 4'(MSG_CHARS - 1));
  assign trigger   = (state == IDLE) && rx_valid && (is_enter || line_full);
  assign printing  = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (!tx_busy) state_nxt = (rom_addr < 4'(LAST_ADDR)) ? FETCH : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_out    <= {MSG_CHARS{8'h20}};
      wr_idx      <= '0;
      rom_addr    <= '0;
      tx_data     <= '0;
      tx_new_data <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      tx_new_data <= 1'b0;
      rx_drop     <= rx_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (rx_valid && !is_enter) begin
            for (int k = 0; k < MSG_CHARS; k++) begin
              if (wr_idx == 4'(k)) bits_out[8*k +: 8] <= rx_data;
            end
            wr_idx <= wr_idx + 4'd1;
          end
          if (trigger) rom_addr <= '0;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data     <= rom_data;
            tx_new_data <= 1'b1;
            if (rom_addr < 4'(LAST_ADDR)) rom_addr <= rom_addr + 4'd1;
          end
        end
        DONE: begin
          bits_out <= {MSG_CHARS{8'h20}};
          wr_idx   <= '0;
          rom_addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keystroke_print_ctrl.sv
// Bench for keystroke_print_ctrl: random lines typed in, printed bytes compared
// against a line-level model (padded characters, then LF, CR).
module tb_keystroke_print_ctrl;

  localparam logic [63:0] SPACES = {8{8'h20}};

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [63:0] bits_out;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  tx_data;
  logic        tx_new_data;
  logic        tx_busy;
  logic        printing;
  logic        rx_drop;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int busy_len = 0;
  int busy_cnt;
  logic [7:0]  exp_q[$];
  logic [63:0] exp_buf;

  keystroke_print_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .bits_out(bits_out), .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_data(tx_data), .tx_new_data(tx_new_data), .tx_busy(tx_busy),
    .printing(printing), .rx_drop(rx_drop), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  // message ROM model: buffer slots, then LF, then CR; one-cycle registered read
  always @(posedge clk) begin
    if (rom_addr < 4'd8)       rom_data <= bits_out[8*rom_addr +: 8];
    else if (rom_addr == 4'd8) rom_data <= 8'h0A;
    else if (rom_addr == 4'd9) rom_data <= 8'h0D;
    else                       rom_data <= 8'hXX;
  end

  // transmitter model: busy for busy_len cycles starting the edge after a strobe
  always @(posedge clk or posedge rst) begin
    if (rst)              busy_cnt <= 0;
    else if (tx_new_data) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && tx_new_data) begin
      strobe_cnt++;
      check("strobe_while_busy", {63'd0, tx_busy}, 64'd0);
      check("bits_hold", bits_out, exp_buf);
      check("rom_addr_range", {63'd0, rom_addr <= 4'd9}, 64'd1);
      check("strobe_expected", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) check("tx_data", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic prep_line(input logic [7:0] chars[8], input int n);
    exp_buf = SPACES;
    for (int i = 0; i < n; i++) exp_buf[8*i +: 8] = chars[i];
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_buf[8*i +: 8]);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h0D);
  endtask

  task automatic type_line(input logic [7:0] chars[8], input int n);
    for (int i = 0; i < n; i++) send_byte(chars[i]);
    if (n < 8) send_byte(8'h0D);
  endtask

  task automatic rand_chars(output logic [7:0] chars[8]);
    for (int i = 0; i < 8; i++) chars[i] = 8'($urandom_range(33, 126));
  endtask

  task automatic run_line(input logic [7:0] chars[8], input int n, input bit drop);
    int base;
    int w;
    bit idle_tx;
    @(negedge clk);
    base = strobe_cnt;
    idle_tx = (busy_cnt == 0);
    prep_line(chars, n);
    type_line(chars, n);
    check("printing_rise", {63'd0, printing}, 64'd1);
    if (idle_tx) begin
      check("lat_c1", {63'd0, tx_new_data}, 64'd0);
      @(negedge clk);
      check("lat_c2", {63'd0, tx_new_data}, 64'd0);
      @(negedge clk);
      check("lat_c3", {63'd0, tx_new_data}, 64'd1);
    end
    if (drop) begin
      repeat (3) @(negedge clk);
      send_byte(8'h31);
      check("rx_drop_pulse", {63'd0, rx_drop}, 64'd1);
      @(negedge clk);
      check("rx_drop_clear", {63'd0, rx_drop}, 64'd0);
    end
    w = 0;
    while (printing && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("print_timeout", {63'd0, w < 5000}, 64'd1);
    check("strobes_per_line", 64'(strobe_cnt - base), 64'd10);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("bits_cleared", bits_out, SPACES);
    check("rom_addr_idle", {60'd0, rom_addr}, 64'd0);
  endtask

  initial begin
    logic [7:0] chars[8];
    int base;
    int w;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_buf  = SPACES;
    repeat (3) @(negedge clk);
    check("rst_bits", bits_out, SPACES);
    check("rst_rom_addr", {60'd0, rom_addr}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_tx_new", {63'd0, tx_new_data}, 64'd0);
    check("rst_drop", {63'd0, rx_drop}, 64'd0);
    check("rst_printing", {63'd0, printing}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full line
    chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    run_line(chars, 8, 1'b0);
    // short line
    chars = '{8'h48, 8'h69, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_line(chars, 2, 1'b0);
    // backpressure
    busy_len = 100;
    rand_chars(chars);
    run_line(chars, 8, 1'b0);
    busy_len = 0;
    repeat (110) @(negedge clk);
    // drop during print, then next line starts at slot 0
    rand_chars(chars);
    run_line(chars, 5, 1'b1);
    rand_chars(chars);
    run_line(chars, 3, 1'b0);

    // mid-print reset after the 4th strobe
    rand_chars(chars);
    @(negedge clk);
    base = strobe_cnt;
    prep_line(chars, 8);
    type_line(chars, 8);
    w = 0;
    while ((strobe_cnt - base) < 4 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("mid_rst_wait", {63'd0, w < 200}, 64'd1);
    rst = 1'b1;
    #1;
    check("mrst_tx_new", {63'd0, tx_new_data}, 64'd0);
    check("mrst_bits", bits_out, SPACES);
    check("mrst_rom_addr", {60'd0, rom_addr}, 64'd0);
    check("mrst_tx_data", {56'd0, tx_data}, 64'd0);
    check("mrst_printing", {63'd0, printing}, 64'd0);
    check("mrst_drop", {63'd0, rx_drop}, 64'd0);
    exp_q.delete();
    base = strobe_cnt;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_strobe_after_rst", 64'(strobe_cnt - base), 64'd0);
    rand_chars(chars);
    run_line(chars, 8, 1'b0);

    // blank line
    run_line(chars, 0, 1'b0);

    // random lines, random backpressure and drops
    for (int t = 0; t < 8; t++) begin
      busy_len = $urandom_range(0, 5);
      rand_chars(chars);
      run_line(chars, $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      repeat (8) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
